// File: rtl/execute_stage.sv
// execute_stage: ALU, branch resolution and EX/MEM pipeline register with stall, squash and sticky halt
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [4:0]        in_alu_op,
  input  logic              in_alu_src,
  input  logic [3:0]        in_jump_type,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [4:0]        in_write_reg,
  input  logic              in_reg_wrenable,
  input  logic              in_mem_wrenable,
  input  logic              in_mem_to_reg,
  input  logic              in_halt,
  input  logic              mem_stall,
  output logic              in_ready,
  output logic              should_jump,
  output logic [PC_W-1:0]   jump_pc,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_result,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_write_reg,
  output logic              ex_reg_wrenable,
  output logic              ex_mem_wrenable,
  output logic              ex_mem_to_reg,
  output logic              halted
);
  logic live, load, taken;
  logic [DATA_W-1:0] b, alu;
  logic [PC_W-1:0] target;
  assign in_ready = !mem_stall;
  // the slot right after a redirect belongs to the wrong path and is dropped
  assign live = in_valid && !mem_stall && !should_jump && !halted;
  assign load = live && !in_halt;
  assign b = in_alu_src ? in_imm : in_rd2;
  assign target = in_jump_type == 4'd1 ? in_imm[PC_W-1:0] : in_pc + PC_W'(1) + in_imm[PC_W-1:0];
  always_comb begin
    case (in_alu_op)
      5'd0: alu = in_rd1 + b;
      5'd1: alu = in_rd1 - b;
      5'd2: alu = in_rd1 & b;
      5'd3: alu = in_rd1 | b;
      5'd4: alu = in_rd1 ^ b;
      5'd5: alu = in_rd1 << b[4:0];
      5'd6: alu = in_rd1 >> b[4:0];
      5'd7: alu = $unsigned($signed(in_rd1) >>> b[4:0]);
      5'd8: alu = {{(DATA_W-1){1'b0}}, $signed(in_rd1) < $signed(b)};
      5'd9: alu = {{(DATA_W-1){1'b0}}, in_rd1 < b};
      default: alu = '0;
    endcase
  end
  always_comb begin
    case (in_jump_type)
      4'd1: taken = 1'b1;
      4'd2: taken = in_rd1 == in_rd2;
      4'd3: taken = in_rd1 != in_rd2;
      4'd4: taken = $signed(in_rd1) < $signed(in_rd2);
      4'd5: taken = $signed(in_rd1) >= $signed(in_rd2);
      default: taken = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      should_jump <= 1'b0;
      jump_pc <= '0;
      ex_valid <= 1'b0;
      ex_alu_result <= '0;
      ex_store_data <= '0;
      ex_write_reg <= '0;
      ex_reg_wrenable <= 1'b0;
      ex_mem_wrenable <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      halted <= 1'b0;
    end else if (!mem_stall) begin
      should_jump <= load && taken;
      if (load && taken) jump_pc <= target;
      ex_valid <= load;
      ex_alu_result <= load ? alu : '0;
      ex_store_data <= load ? in_rd2 : '0;
      ex_write_reg <= load ? in_write_reg : '0;
      ex_reg_wrenable <= load && in_reg_wrenable && |in_write_reg;
      ex_mem_wrenable <= load && in_mem_wrenable;
      ex_mem_to_reg <= load && in_mem_to_reg;
      halted <= halted || (live && in_halt);
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model
module tb_execute_stage;
  localparam int DW = 32;
  localparam int PW = 5;
  logic clk = 0, rst_n, in_valid, in_alu_src, in_reg_wrenable, in_mem_wrenable, in_mem_to_reg, in_halt, mem_stall;
  logic [DW-1:0] in_rd1, in_rd2, in_imm;
  logic [4:0] in_alu_op, in_write_reg;
  logic [3:0] in_jump_type;
  logic [PW-1:0] in_pc;
  logic in_ready, should_jump, ex_valid, ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg, halted;
  logic [PW-1:0] jump_pc;
  logic [DW-1:0] ex_alu_result, ex_store_data;
  logic [4:0] ex_write_reg;
  int n_chk = 0, n_fail = 0;
  logic m_valid, m_sj, m_halted, m_rwe, m_mwe, m_m2r;
  logic [PW-1:0] m_jpc;
  logic [DW-1:0] m_res, m_sd;
  logic [4:0] m_wr;

  execute_stage #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_jump_type(in_jump_type), .in_pc(in_pc),
    .in_write_reg(in_write_reg), .in_reg_wrenable(in_reg_wrenable), .in_mem_wrenable(in_mem_wrenable),
    .in_mem_to_reg(in_mem_to_reg), .in_halt(in_halt), .mem_stall(mem_stall), .in_ready(in_ready),
    .should_jump(should_jump), .jump_pc(jump_pc), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_reg_wrenable(ex_reg_wrenable),
    .ex_mem_wrenable(ex_mem_wrenable), .ex_mem_to_reg(ex_mem_to_reg), .halted(halted));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f_alu(int op, logic [DW-1:0] a, logic [DW-1:0] b);
    int sh;
    sh = b % 32;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return $unsigned($signed(a) >>> sh);
      8: return ($signed(a) < $signed(b)) ? 1 : 0;
      9: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit f_taken(int jt, logic [DW-1:0] a, logic [DW-1:0] b);
    case (jt)
      1: return 1;
      2: return a == b;
      3: return a != b;
      4: return $signed(a) < $signed(b);
      5: return $signed(a) >= $signed(b);
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, !mem_stall);
    chk("ex_valid", ex_valid, m_valid);
    chk("should_jump", should_jump, m_sj);
    if (m_sj) chk("jump_pc", jump_pc, m_jpc);
    chk("halted", halted, m_halted);
    chk("ex_reg_wrenable", ex_reg_wrenable, m_rwe);
    chk("ex_mem_wrenable", ex_mem_wrenable, m_mwe);
    if (m_valid) begin
      chk("ex_alu_result", ex_alu_result, m_res);
      chk("ex_store_data", ex_store_data, m_sd);
      chk("ex_write_reg", ex_write_reg, m_wr);
      chk("ex_mem_to_reg", ex_mem_to_reg, m_m2r);
    end
  endtask

  task automatic step();
    bit live, ld, tk;
    if (!rst_n) begin
      {m_valid, m_sj, m_halted, m_rwe, m_mwe, m_m2r} = '0;
      m_jpc = 0; m_res = 0; m_sd = 0; m_wr = 0;
    end else if (!mem_stall) begin
      live = in_valid && !m_sj && !m_halted;
      ld = live && !in_halt;
      tk = f_taken(int'(in_jump_type), in_rd1, in_rd2);
      m_sj = ld && tk;
      if (m_sj) m_jpc = (in_jump_type == 1) ? PW'(in_imm % 32) : PW'((int'(in_pc) + 1 + int'(in_imm % 32)) % 32);
      m_valid = ld;
      m_res = ld ? f_alu(int'(in_alu_op), in_rd1, in_alu_src ? in_imm : in_rd2) : 0;
      m_sd = ld ? in_rd2 : 0;
      m_wr = ld ? in_write_reg : 0;
      m_rwe = ld && in_reg_wrenable && in_write_reg != 0;
      m_mwe = ld && in_mem_wrenable;
      m_m2r = ld && in_mem_to_reg;
      if (live && in_halt) m_halted = 1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic instr(int op, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] imm, bit src, int jt,
                       int pc, int wr, bit rwe, bit halt);
    in_valid = 1; in_alu_op = 5'(op); in_rd1 = a; in_rd2 = b; in_imm = imm; in_alu_src = src;
    in_jump_type = 4'(jt); in_pc = PW'(pc); in_write_reg = 5'(wr); in_reg_wrenable = rwe;
    in_mem_wrenable = 0; in_mem_to_reg = 0; in_halt = halt;
  endtask

  initial begin
    rst_n = 0; mem_stall = 1;
    instr(0, 1, 2, 3, 0, 1, 4, 5, 1, 0);
    step();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst should_jump", should_jump, 0);
    chk("rst jump_pc", jump_pc, 0);
    chk("rst ex_alu_result", ex_alu_result, 0);
    chk("rst ex_write_reg", ex_write_reg, 0);
    rst_n = 1; mem_stall = 0;
    instr(0, 7, 5, 0, 0, 0, 0, 3, 1, 0);
    step();
    chk("add result", ex_alu_result, 12);
    chk("add valid", ex_valid, 1);
    chk("add wr", ex_write_reg, 3);
    chk("add rwe", ex_reg_wrenable, 1);
    instr(0, 9, 9, 4, 0, 2, 30, 1, 1, 0);
    step();
    chk("beq sj", should_jump, 1);
    chk("beq jump_pc", jump_pc, 3);
    instr(0, 1, 1, 0, 0, 0, 0, 2, 1, 0);
    step();
    chk("squash valid", ex_valid, 0);
    chk("squash sj", should_jump, 0);
    instr(0, 9, 9, 4, 0, 3, 10, 1, 1, 0);
    step();
    chk("bne sj", should_jump, 0);
    instr(0, 2, 3, 0, 0, 0, 0, 2, 1, 0);
    step();
    chk("after bne valid", ex_valid, 1);
    chk("after bne result", ex_alu_result, 5);
    instr(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("sub result", ex_alu_result, 32'hFFFF_FFFF);
    chk("sub rwe", ex_reg_wrenable, 0);
    instr(8, -5, 2, 0, 0, 0, 0, 4, 1, 0);
    mem_stall = 1;
    repeat (3) begin
      step();
      chk("stall in_ready", in_ready, 0);
      chk("stall frozen", ex_alu_result, 32'hFFFF_FFFF);
    end
    mem_stall = 0;
    step();
    chk("slt result", ex_alu_result, 1);
    chk("slt valid", ex_valid, 1);
    in_valid = 0;
    step();
    chk("slt not dup", ex_valid, 0);
    instr(0, 1, 1, 0, 0, 1, 0, 1, 1, 1);
    step();
    chk("halt set", halted, 1);
    chk("halt bubble", ex_valid, 0);
    chk("halt no jump", should_jump, 0);
    instr(0, 7, 5, 0, 0, 0, 0, 3, 1, 0);
    step();
    chk("halt sticky", halted, 1);
    chk("halt ignore", ex_valid, 0);
    rst_n = 0;
    step();
    chk("rst clears halted", halted, 0);
    chk("rst clears result", ex_alu_result, 0);
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      mem_stall = $urandom_range(0, 4) == 0;
      instr($urandom_range(0, 15), $urandom_range(0, 1) ? $urandom : $urandom_range(0, 7) - 4, 0,
            $urandom, $urandom_range(0, 1), $urandom_range(0, 2) ? $urandom_range(0, 6) : $urandom_range(0, 15),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 79) == 0);
      in_rd2 = $urandom_range(0, 2) == 0 ? in_rd1 : ($urandom_range(0, 1) ? $urandom : $urandom_range(0, 7) - 4);
      in_valid = $urandom_range(0, 4) != 0;
      in_mem_wrenable = $urandom_range(0, 1);
      in_mem_to_reg = $urandom_range(0, 1);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 The module SHALL have parameter PC_W, default 5, meaning program counter width.
REQ-003 The port list SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  fetch_decode presents an instruction
- in_rd1, in_rd2, in_imm  in  DATA_W each  register operands, sign-extended immediate
- in_alu_op  in  5  ALU operation
- in_alu_src  in  1  1 = operand B is in_imm, 0 = in_rd2
- in_jump_type  in  4  control-transfer kind
- in_pc  in  PC_W  instruction PC
- in_write_reg  in  5  destination register
- in_reg_wrenable, in_mem_wrenable, in_mem_to_reg, in_halt  in  1 each  decoded controls
- mem_stall  in  1  downstream MEM-WB cannot accept
- in_ready  out  1  = !mem_stall; instruction accepted when in_valid & in_ready
- should_jump  out  1  registered redirect pulse to fetch_decode
- jump_pc  out  PC_W  redirect target, valid when should_jump=1
- ex_valid  out  1  EX/MEM register holds a live instruction
- ex_alu_result, ex_store_data  out  DATA_W each  ALU result, in_rd2 copy
- ex_write_reg  out  5  destination register
- ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg  out  1 each  forwarded controls
- halted  out  1  sticky halt flag

Function
REQ-004 ALU ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; shifts use B[4:0]; all other codes yield 0.
REQ-005 Arithmetic SHALL be modulo 2^DATA_W with no overflow flag.
REQ-006 Jump types SHALL be: 0 none, 1 JMP, 2 BEQ (rd1==rd2), 3 BNE, 4 BLT (signed rd1<rd2), 5 BGE (signed rd1>=rd2); codes 6-15 behave as none.
REQ-007 JMP target SHALL be in_imm[PC_W-1:0]; branch target SHALL be in_pc+1+in_imm[PC_W-1:0], wrapping modulo 2^PC_W.
REQ-008 An instruction is "live" when accepted, not squashed, and halted=0; only live instructions update state.
REQ-009 A live instruction SHALL load the EX/MEM register on the next edge, setting ex_valid=1; latency is 1 cycle.
REQ-010 ex_reg_wrenable SHALL be forced to 0 when in_write_reg==0.
REQ-011 On a live taken jump/branch, should_jump SHALL be 1 for exactly the next cycle with jump_pc = target; otherwise should_jump=0.
REQ-012 Squash: the instruction presented in the cycle should_jump=1 SHALL be discarded as a bubble (ex_valid=0 next cycle); only that one cycle is squashed.
REQ-013 A non-live cycle with mem_stall=0 SHALL load a bubble: ex_valid=0 and ex_reg_wrenable=ex_mem_wrenable=0.
REQ-014 With mem_stall=1, the EX/MEM register, should_jump, and jump_pc SHALL hold, and no input is consumed.
REQ-015 A live instruction with in_halt=1 SHALL set halted=1 on the next edge and pass downstream as a bubble with no writes or jump.
REQ-016 While halted=1, all inputs SHALL be ignored and bubbles loaded when not stalled; only reset clears halted.
REQ-017 A live instruction with both a taken jump and halt SHALL take precedence as halt, with no redirect.

Reset
REQ-018 With rst_n=0 at an edge: ex_valid=0, should_jump=0, jump_pc=0, halted=0, ex_alu_result=0, ex_store_data=0, ex_write_reg=0, and all ex_* enables 0.
REQ-019 Reset SHALL override mem_stall and any in-flight instruction; the first live instruction is accepted on the first edge with rst_n=1.

Verification
REQ-020 ADD with rd1=7, rd2=5, alu_src=0, write_reg=3, wrenable=1 -> next cycle ex_valid=1, ex_alu_result=12, ex_write_reg=3, ex_reg_wrenable=1.
REQ-021 BEQ with rd1=rd2=9, pc=30, imm=4, then any instruction -> should_jump=1 and jump_pc=3 (wraps) for one cycle; the following instruction yields ex_valid=0.
REQ-022 BNE with rd1=rd2 -> should_jump stays 0; the next instruction is not squashed.
REQ-023 SUB 0-1 with write_reg=0 -> ex_alu_result=0xFFFFFFFF, ex_reg_wrenable=0.
REQ-024 mem_stall=1 for 3 cycles holding an instruction with SLT -5<2 -> outputs frozen and in_ready=0; after release, one result of 1, not duplicated.
REQ-025 Halt instruction, then ADD -> halted=1 sticky, ex_valid=0 thereafter; rst_n=0 for 1 cycle clears halted and all outputs to 0.
